// File: rtl/axi_reg_slave.sv
// AXI4 single-beat slave bridging onto a native register bus (addr/write/read/readvalid).
// Latency: write 1 cycle after the later of AW/W to reg_write, B one cycle later; read strobe 1 cycle after AR.
// Backpressure: one-entry AW and W slots (ready = slot empty); B/R held until bready/rready.
//
// Ports: clk, rst (sync, active-high); slv_axi_aw*/w*/b* write channels; slv_axi_ar*/r* read
// channels; reg_addr/reg_write/reg_writedata/reg_byteenable/reg_read out to the register banks,
// reg_readdata/reg_readvalid back from them.
module axi_reg_slave #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    REG_ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    RD_TIMEOUT     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                slv_axi_awid,
   input  logic [ADDR_WIDTH-1:0]     slv_axi_awaddr,
   input  logic [7:0]                slv_axi_awlen,
   input  logic [2:0]                slv_axi_awsize,
   input  logic                      slv_axi_awvalid,
   output logic                      slv_axi_awready,
   input  logic [31:0]               slv_axi_wdata,
   input  logic [3:0]                slv_axi_wstrb,
   input  logic                      slv_axi_wlast,
   input  logic                      slv_axi_wvalid,
   output logic                      slv_axi_wready,
   output logic [3:0]                slv_axi_bid,
   output logic [1:0]                slv_axi_bresp,
   output logic                      slv_axi_bvalid,
   input  logic                      slv_axi_bready,
   input  logic [3:0]                slv_axi_arid,
   input  logic [ADDR_WIDTH-1:0]     slv_axi_araddr,
   input  logic [7:0]                slv_axi_arlen,
   input  logic [2:0]                slv_axi_arsize,
   input  logic                      slv_axi_arvalid,
   output logic                      slv_axi_arready,
   output logic [3:0]                slv_axi_rid,
   output logic [31:0]               slv_axi_rdata,
   output logic [1:0]                slv_axi_rresp,
   output logic                      slv_axi_rlast,
   output logic                      slv_axi_rvalid,
   input  logic                      slv_axi_rready,
   output logic [REG_ADDR_WIDTH-1:0] reg_addr,
   output logic                      reg_write,
   output logic [31:0]               reg_writedata,
   output logic [3:0]                reg_byteenable,
   output logic                      reg_read,
   input  logic [31:0]               reg_readdata,
   input  logic                      reg_readvalid
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_EXEC = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_RESP = 3'd4;
   localparam int         CW        = $clog2(RD_TIMEOUT + 1);

   logic [2:0]                state;
   logic                      aw_full, w_full;
   logic [3:0]                aw_id_q;
   logic [ADDR_WIDTH-1:0]     aw_addr_q;
   logic [7:0]                aw_len_q;
   logic [2:0]                aw_size_q;
   logic [31:0]               w_data_q;
   logic [3:0]                w_strb_q;
   logic [3:0]                acc_id;
   logic [REG_ADDR_WIDTH-1:0] acc_addr;
   logic                      acc_err;
   logic [31:0]               wr_data_q;
   logic [3:0]                wr_strb_q;
   logic [31:0]               rdata_q;
   logic [1:0]                rresp_q;
   logic [CW-1:0]             rd_cnt;

   logic                      aw_hs, w_hs, ar_hs, go_wr;
   logic [3:0]                wr_id_m;
   logic [ADDR_WIDTH-1:0]     wr_addr_m, wr_off, rd_off;
   logic [7:0]                wr_len_m;
   logic [2:0]                wr_size_m;
   logic [31:0]               wr_data_m;
   logic [3:0]                wr_strb_m;
   logic                      wr_err, rd_err;
   logic                      unused_bits;

   assign slv_axi_awready = !rst && !aw_full;
   assign slv_axi_wready  = !rst && !w_full;
   assign aw_hs = slv_axi_awvalid && slv_axi_awready;
   assign w_hs  = slv_axi_wvalid && slv_axi_wready;

   // A channel handshaking this cycle counts as present, so a pair can start
   // executing the cycle after the later handshake without parking in a slot.
   assign go_wr = (state == S_IDLE) && (aw_full || aw_hs) && (w_full || w_hs);

   // Write pair wins over a simultaneous AR.
   assign slv_axi_arready = !rst && (state == S_IDLE) && !go_wr;
   assign ar_hs = slv_axi_arvalid && slv_axi_arready;

   assign wr_id_m   = aw_full ? aw_id_q   : slv_axi_awid;
   assign wr_addr_m = aw_full ? aw_addr_q : slv_axi_awaddr;
   assign wr_len_m  = aw_full ? aw_len_q  : slv_axi_awlen;
   assign wr_size_m = aw_full ? aw_size_q : slv_axi_awsize;
   assign wr_data_m = w_full  ? w_data_q  : slv_axi_wdata;
   assign wr_strb_m = w_full  ? w_strb_q  : slv_axi_wstrb;

   // Addresses below BASE_ADDR wrap to a huge offset and fail the window test.
   assign wr_off = wr_addr_m - BASE_ADDR;
   assign rd_off = slv_axi_araddr - BASE_ADDR;
   assign wr_err = (wr_len_m != 8'd0) || (wr_size_m != 3'b010) ||
                   ((wr_off >> (REG_ADDR_WIDTH + 2)) != '0);
   assign rd_err = (slv_axi_arlen != 8'd0) || (slv_axi_arsize != 3'b010) ||
                   ((rd_off >> (REG_ADDR_WIDTH + 2)) != '0);

   // Byte-lane bits and wlast carry no information for single-word accesses.
   assign unused_bits = ^{slv_axi_wlast, wr_off[1:0], rd_off[1:0]};

   assign slv_axi_bvalid = (state == S_WR_RESP);
   assign slv_axi_bid    = acc_id;
   assign slv_axi_bresp  = (slv_axi_bvalid && acc_err) ? 2'b10 : 2'b00;
   assign slv_axi_rvalid = (state == S_RD_RESP);
   assign slv_axi_rlast  = (state == S_RD_RESP);
   assign slv_axi_rid    = acc_id;
   assign slv_axi_rdata  = rdata_q;
   assign slv_axi_rresp  = rresp_q;

   assign reg_addr       = acc_addr;
   assign reg_writedata  = wr_data_q;
   assign reg_byteenable = wr_strb_q;
   assign reg_write      = (state == S_WR_EXEC) && !acc_err;
   assign reg_read       = (state == S_RD_REQ) && (rd_cnt == '0) && !acc_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_id_q   <= '0;
         aw_addr_q <= '0;
         aw_len_q  <= '0;
         aw_size_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         acc_id    <= '0;
         acc_addr  <= '0;
         acc_err   <= 1'b0;
         wr_data_q <= '0;
         wr_strb_q <= '0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         rd_cnt    <= '0;
      end else begin
         // Slots: a consumed pair never leaves a handshaking channel parked.
         if (go_wr) begin
            aw_full <= 1'b0;
         end else if (aw_hs) begin
            aw_full   <= 1'b1;
            aw_id_q   <= slv_axi_awid;
            aw_addr_q <= slv_axi_awaddr;
            aw_len_q  <= slv_axi_awlen;
            aw_size_q <= slv_axi_awsize;
         end
         if (go_wr) begin
            w_full <= 1'b0;
         end else if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= slv_axi_wdata;
            w_strb_q <= slv_axi_wstrb;
         end

         case (state)
            S_IDLE: begin
               if (go_wr) begin
                  acc_id    <= wr_id_m;
                  acc_addr  <= wr_off[REG_ADDR_WIDTH+1:2];
                  acc_err   <= wr_err;
                  wr_data_q <= wr_data_m;
                  wr_strb_q <= wr_strb_m;
                  state     <= S_WR_EXEC;
               end else if (ar_hs) begin
                  acc_id   <= slv_axi_arid;
                  acc_addr <= rd_off[REG_ADDR_WIDTH+1:2];
                  acc_err  <= rd_err;
                  rd_cnt   <= '0;
                  state    <= S_RD_REQ;
               end
            end
            S_WR_EXEC: state <= S_WR_RESP;
            S_WR_RESP: if (slv_axi_bready) state <= S_IDLE;
            S_RD_REQ: begin
               if (acc_err) begin
                  rdata_q <= '0;
                  rresp_q <= 2'b10;
                  state   <= S_RD_RESP;
               end else if (reg_readvalid) begin
                  rdata_q <= reg_readdata;
                  rresp_q <= 2'b00;
                  state   <= S_RD_RESP;
               end else if (rd_cnt == CW'(RD_TIMEOUT - 1)) begin
                  rdata_q <= '0;
                  rresp_q <= 2'b10;
                  state   <= S_RD_RESP;
               end else begin
                  rd_cnt <= rd_cnt + 1'b1;
               end
            end
            S_RD_RESP: if (slv_axi_rready) state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_reg_slave.sv
// Scoreboard bench for axi_reg_slave: B/R expectations are queued when stimulus is
// driven and compared by a monitor on each handshake; register-bus strobes are checked inline.
module tb_axi_reg_slave;

   localparam int                AW   = 32;
   localparam int                RAW  = 8;
   localparam logic [AW-1:0]     BASE = 32'h0001_0000;
   localparam int                TO   = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [3:0]      awid = '0;
   logic [AW-1:0]   awaddr = '0;
   logic [7:0]      awlen = '0;
   logic [2:0]      awsize = 3'b010;
   logic            awvalid = 1'b0, awready;
   logic [31:0]     wdata = '0;
   logic [3:0]      wstrb = '0;
   logic            wlast = 1'b1, wvalid = 1'b0, wready;
   logic [3:0]      bid;
   logic [1:0]      bresp;
   logic            bvalid, bready = 1'b1;
   logic [3:0]      arid = '0;
   logic [AW-1:0]   araddr = '0;
   logic [7:0]      arlen = '0;
   logic [2:0]      arsize = 3'b010;
   logic            arvalid = 1'b0, arready;
   logic [3:0]      rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast, rvalid, rready = 1'b1;
   logic [RAW-1:0]  reg_addr;
   logic            reg_write, reg_read;
   logic [31:0]     reg_writedata;
   logic [3:0]      reg_byteenable;
   logic [31:0]     reg_readdata = '0;
   logic            reg_readvalid = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int n_wr     = 0;
   int n_rd     = 0;
   logic [5:0]  exp_b[$];   // {bid, bresp}
   logic [38:0] exp_r[$];   // {rid, rresp, rdata, rlast}

   always #5 clk = ~clk;

   axi_reg_slave #(.ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RAW), .BASE_ADDR(BASE), .RD_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .slv_axi_awid(awid), .slv_axi_awaddr(awaddr), .slv_axi_awlen(awlen), .slv_axi_awsize(awsize),
      .slv_axi_awvalid(awvalid), .slv_axi_awready(awready),
      .slv_axi_wdata(wdata), .slv_axi_wstrb(wstrb), .slv_axi_wlast(wlast),
      .slv_axi_wvalid(wvalid), .slv_axi_wready(wready),
      .slv_axi_bid(bid), .slv_axi_bresp(bresp), .slv_axi_bvalid(bvalid), .slv_axi_bready(bready),
      .slv_axi_arid(arid), .slv_axi_araddr(araddr), .slv_axi_arlen(arlen), .slv_axi_arsize(arsize),
      .slv_axi_arvalid(arvalid), .slv_axi_arready(arready),
      .slv_axi_rid(rid), .slv_axi_rdata(rdata), .slv_axi_rresp(rresp), .slv_axi_rlast(rlast),
      .slv_axi_rvalid(rvalid), .slv_axi_rready(rready),
      .reg_addr(reg_addr), .reg_write(reg_write), .reg_writedata(reg_writedata),
      .reg_byteenable(reg_byteenable), .reg_read(reg_read),
      .reg_readdata(reg_readdata), .reg_readvalid(reg_readvalid)
   );

   // Strobe counters, used to prove that error accesses never reach the register bus.
   always @(posedge clk) begin
      if (reg_write) n_wr++;
      if (reg_read)  n_rd++;
   end

   // Scoreboard monitor: every B/R handshake pops and compares one expectation.
   always @(negedge clk) begin
      if (!rst && bvalid && bready) begin
         n_checks++;
         if (exp_b.size() == 0) begin
            n_fail++; $display("FAIL b_unexpected: got bid=%0h bresp=%0h, required none", bid, bresp);
         end else begin
            logic [5:0] e;
            e = exp_b.pop_front();
            if ({bid, bresp} !== e) begin
               n_fail++; $display("FAIL b_resp: got {bid,bresp}=%h, required %h", {bid, bresp}, e);
            end
         end
      end
      if (!rst && rvalid && rready) begin
         n_checks++;
         if (exp_r.size() == 0) begin
            n_fail++; $display("FAIL r_unexpected: got rid=%0h rdata=%h, required none", rid, rdata);
         end else begin
            logic [38:0] e;
            e = exp_r.pop_front();
            if ({rid, rresp, rdata, rlast} !== e) begin
               n_fail++; $display("FAIL r_resp: got {rid,rresp,rdata,rlast}=%h, required %h",
                                  {rid, rresp, rdata, rlast}, e);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      repeat (3) step();
      @(negedge clk);
      n_checks++;
      if ({awready, wready, arready} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ready_low: got %b, required 000", {awready, wready, arready});
      end
      step(); rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_fail++; $display("FAIL reset_ready_high: got %b, required 111", {awready, wready, arready});
      end
      n_checks++;
      if ({bvalid, rvalid, rlast, reg_write, reg_read, bresp, rresp, bid, rid} !== 17'd0) begin
         n_fail++; $display("FAIL reset_ctrl: got %h, required 0",
                            {bvalid, rvalid, rlast, reg_write, reg_read, bresp, rresp, bid, rid});
      end
      n_checks++;
      if ({rdata, reg_addr, reg_writedata, reg_byteenable} !== 76'd0) begin
         n_fail++; $display("FAIL reset_data: got %h, required 0", {rdata, reg_addr, reg_writedata, reg_byteenable});
      end
   endtask

   task automatic test_write_basic;
      step();
      awid = 4'h5; awaddr = BASE + 32'h08; awlen = 0; awsize = 3'b010; awvalid = 1'b1;
      wdata = 32'hA5A5_1234; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      exp_b.push_back({4'h5, 2'b00});
      step(); awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({reg_write, reg_addr, reg_writedata, reg_byteenable} !== {1'b1, 8'd2, 32'hA5A5_1234, 4'hF}) begin
         n_fail++; $display("FAIL wr_basic_strobe: got we=%b a=%0d d=%h be=%h, required 1 2 a5a51234 f",
                            reg_write, reg_addr, reg_writedata, reg_byteenable);
      end
      step(); @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1) begin
         n_fail++; $display("FAIL wr_basic_bvalid_c2: got %b, required 1", bvalid);
      end
      step(); @(negedge clk);
      n_checks++;
      if ({bvalid, arready} !== 2'b01) begin
         n_fail++; $display("FAIL wr_basic_idle_c3: got bvalid,arready=%b, required 01", {bvalid, arready});
      end
   endtask

   task automatic test_w_before_aw;
      int wr0;
      step();
      wdata = 32'h1111_2222; wstrb = 4'h3; wvalid = 1'b1;
      wr0 = n_wr;
      step(); wvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wready, reg_write} !== 2'b00) begin
         n_fail++; $display("FAIL w_first_parked: got wready,reg_write=%b, required 00", {wready, reg_write});
      end
      step();
      awid = 4'h3; awaddr = BASE + 32'h0C; awvalid = 1'b1;
      exp_b.push_back({4'h3, 2'b00});
      @(negedge clk);
      n_checks++;
      if (n_wr !== wr0) begin
         n_fail++; $display("FAIL w_first_no_early_write: got %0d strobes, required 0", n_wr - wr0);
      end
      step(); awvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({reg_write, reg_addr, reg_writedata, reg_byteenable} !== {1'b1, 8'd3, 32'h1111_2222, 4'h3}) begin
         n_fail++; $display("FAIL w_first_strobe: got we=%b a=%0d d=%h be=%h, required 1 3 11112222 3",
                            reg_write, reg_addr, reg_writedata, reg_byteenable);
      end
      step(); @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1) begin
         n_fail++; $display("FAIL w_first_bvalid: got %b, required 1", bvalid);
      end
      step();
   endtask

   task automatic test_pipelined_write;
      step();
      awid = 4'h1; awaddr = BASE + 32'h24; awvalid = 1'b1;
      wdata = 32'h0000_0001; wstrb = 4'hF; wvalid = 1'b1;
      exp_b.push_back({4'h1, 2'b00});
      step();
      @(negedge clk);
      n_checks++;
      if ({awready, wready, reg_write, reg_addr} !== {3'b111, 8'd9}) begin
         n_fail++; $display("FAIL pipe_accept_in_exec: got %b_%0d, required 111_9",
                            {awready, wready, reg_write}, reg_addr);
      end
      awid = 4'h2; awaddr = BASE + 32'h28; wdata = 32'h0000_0002;
      exp_b.push_back({4'h2, 2'b00});
      step(); awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({awready, wready, bvalid} !== 3'b001) begin
         n_fail++; $display("FAIL pipe_slots_full: got %b, required 001", {awready, wready, bvalid});
      end
      step(); step(); @(negedge clk);
      n_checks++;
      if ({reg_write, reg_addr, reg_writedata} !== {1'b1, 8'd10, 32'h2}) begin
         n_fail++; $display("FAIL pipe_second_strobe: got we=%b a=%0d d=%h, required 1 10 2",
                            reg_write, reg_addr, reg_writedata);
      end
      step(); step();
   endtask

   task automatic test_read_delay;
      step();
      arid = 4'h7; araddr = BASE + 32'h10; arvalid = 1'b1; rready = 1'b0;
      step(); arvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({reg_read, reg_addr} !== {1'b1, 8'd4}) begin
         n_fail++; $display("FAIL rd_strobe: got rd=%b a=%0d, required 1 4", reg_read, reg_addr);
      end
      step(); @(negedge clk);
      n_checks++;
      if (reg_read !== 1'b0) begin
         n_fail++; $display("FAIL rd_strobe_one_cycle: got %b, required 0", reg_read);
      end
      step(); step();
      reg_readvalid = 1'b1; reg_readdata = 32'hCAFE_F00D;
      exp_r.push_back({4'h7, 2'b00, 32'hCAFE_F00D, 1'b1});
      step(); reg_readvalid = 1'b0; reg_readdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rvalid, rid, rresp, rdata, rlast} !== {1'b1, 4'h7, 2'b00, 32'hCAFE_F00D, 1'b1}) begin
            n_fail++; $display("FAIL rd_hold_%0d: got v=%b id=%0h resp=%0h d=%h last=%b, required 1 7 0 cafef00d 1",
                               i, rvalid, rid, rresp, rdata, rlast);
         end
         if (i == 0) step();
      end
      step(); rready = 1'b1;
      step(); @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b0) begin
         n_fail++; $display("FAIL rd_release: got rvalid=%b, required 0", rvalid);
      end
   endtask

   task automatic test_read_timeout;
      int first;
      first = -1;
      step();
      arid = 4'h2; araddr = BASE + 32'h20; arvalid = 1'b1; rready = 1'b1;
      exp_r.push_back({4'h2, 2'b10, 32'h0, 1'b1});
      for (int c = 1; c <= 40 && first < 0; c++) begin
         step();
         arvalid = 1'b0;
         @(negedge clk);
         if (rvalid) first = c;
      end
      n_checks++;
      if (first !== TO + 1) begin
         n_fail++; $display("FAIL rd_timeout_latency: got cycle %0d, required %0d", first, TO + 1);
      end
      step();
      reg_readvalid = 1'b1; reg_readdata = 32'hDEAD_BEEF;
      step(); reg_readvalid = 1'b0;
      step(); @(negedge clk);
      n_checks++;
      if ({rvalid, arready} !== 2'b01) begin
         n_fail++; $display("FAIL rd_late_data_ignored: got rvalid,arready=%b, required 01", {rvalid, arready});
      end
   endtask

   task automatic test_errors;
      int wr0, rd0;
      wr0 = n_wr; rd0 = n_rd;
      for (int t = 0; t < 2; t++) begin
         step();
         awid = (t == 0) ? 4'h9 : 4'hA; awaddr = BASE + 32'h04;
         awlen = (t == 0) ? 8'd1 : 8'd0; awsize = (t == 0) ? 3'b010 : 3'b011;
         awvalid = 1'b1; wdata = 32'hFFFF_0000; wstrb = 4'hF; wvalid = 1'b1;
         exp_b.push_back({awid, 2'b10});
         step(); awvalid = 1'b0; wvalid = 1'b0; awlen = 8'd0; awsize = 3'b010;
         step(); @(negedge clk);
         n_checks++;
         if ({bvalid, bresp} !== 3'b110) begin
            n_fail++; $display("FAIL wr_err_%0d: got bvalid,bresp=%b, required 110", t, {bvalid, bresp});
         end
         step();
      end
      step();
      arid = 4'h1; araddr = BASE + (32'h4 << RAW); arvalid = 1'b1;
      exp_r.push_back({4'h1, 2'b10, 32'h0, 1'b1});
      step(); arvalid = 1'b0;
      step(); @(negedge clk);
      n_checks++;
      if ({rvalid, rresp} !== 3'b110) begin
         n_fail++; $display("FAIL rd_err_window: got rvalid,rresp=%b, required 110", {rvalid, rresp});
      end
      step(); @(negedge clk);
      n_checks++;
      if ((n_wr - wr0) !== 0 || (n_rd - rd0) !== 0) begin
         n_fail++; $display("FAIL err_no_strobes: got writes=%0d reads=%0d, required 0 0", n_wr - wr0, n_rd - rd0);
      end
   endtask

   task automatic test_back_to_back;
      step();
      awid = 4'h4; awaddr = BASE + 32'h18; awvalid = 1'b1;
      wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wvalid = 1'b1;
      arid = 4'h6; araddr = BASE + 32'h1C; arvalid = 1'b1;
      exp_b.push_back({4'h4, 2'b00});
      exp_r.push_back({4'h6, 2'b00, 32'h5555_AAAA, 1'b1});
      @(negedge clk);
      n_checks++;
      if (arready !== 1'b0) begin
         n_fail++; $display("FAIL b2b_write_wins: got arready=%b, required 0", arready);
      end
      step(); awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({reg_write, arready} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_write_first: got reg_write,arready=%b, required 10", {reg_write, arready});
      end
      step(); step(); @(negedge clk);
      n_checks++;
      if (arready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_ar_after_write: got arready=%b, required 1", arready);
      end
      step(); arvalid = 1'b0;
      reg_readvalid = 1'b1; reg_readdata = 32'h5555_AAAA;
      @(negedge clk);
      n_checks++;
      if ({reg_read, reg_addr} !== {1'b1, 8'd7}) begin
         n_fail++; $display("FAIL b2b_read_strobe: got rd=%b a=%0d, required 1 7", reg_read, reg_addr);
      end
      step(); reg_readvalid = 1'b0; reg_readdata = 32'h0;
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_zero_latency_rvalid: got %b, required 1", rvalid);
      end
      step();
   endtask

   task automatic test_reset_mid_read;
      int seen;
      seen = 0;
      step();
      arid = 4'h5; araddr = BASE + 32'h04; arvalid = 1'b1; rready = 1'b1;
      step(); arvalid = 1'b0;
      step(); rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({awready, wready, arready} !== 3'b000) begin
         n_fail++; $display("FAIL mid_rst_ready_low: got %b, required 000", {awready, wready, arready});
      end
      step(); rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rvalid, bvalid, reg_read, reg_write, rdata, reg_addr, arready} !== {4'b0000, 32'h0, 8'd0, 1'b1}) begin
         n_fail++; $display("FAIL mid_rst_outputs: got v=%b rd=%h a=%0d arready=%b, required 0000 0 0 1",
                            {rvalid, bvalid, reg_read, reg_write}, rdata, reg_addr, arready);
      end
      step(); reg_readvalid = 1'b1; reg_readdata = 32'h1234_5678;
      step(); reg_readvalid = 1'b0;
      for (int i = 0; i < TO + 4; i++) begin
         @(negedge clk);
         if (rvalid) seen++;
         step();
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL mid_rst_no_r: got %0d rvalid cycles, required 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_w_before_aw();
      test_pipelined_write();
      test_read_delay();
      test_read_timeout();
      test_errors();
      test_back_to_back();
      test_reset_mid_read();
      n_checks++;
      if (exp_b.size() != 0 || exp_r.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d B and %0d R outstanding, required 0 0",
                            exp_b.size(), exp_r.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
